// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a one-cycle trmt strobe loads a byte that is sent LSB-first,
// each bit held for BAUD_DIV clocks, with a sticky tx_done flag on completion.
module uart_tx #(
  parameter int BAUD_DIV  = 2604,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 clr_done,
  output logic                 TX,
  output logic                 busy,
  output logic                 tx_done
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS + 1);

  typedef enum logic {IDLE, XMIT} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS:0]   shift_reg, shift_nxt;
  logic [11:0]          baud_cnt, baud_nxt;
  logic [3:0]           bit_cnt, bit_nxt;
  logic                 busy_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      busy      <= busy_nxt;
      tx_done   <= done_nxt;
    end
  end

  // Completion is evaluated after the clear so that set wins on a shared edge.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    busy_nxt  = busy;
    done_nxt  = tx_done;
    if (clr_done) done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (trmt) begin
          shift_nxt = {tx_data, 1'b0};
          baud_nxt  = '0;
          bit_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          state_nxt = XMIT;
        end
      end
      XMIT: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          shift_nxt = {1'b1, shift_reg[DATA_BITS:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_nxt   = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end else begin
          baud_nxt = baud_cnt + 12'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign TX = shift_reg[0];

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at BAUD_DIV=16; frames are captured by
// mid-bit sampling and compared against hand-computed 10-bit frame words.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clr_done = 1'b0;
  logic       TX, busy, tx_done;

  int compare_count = 0;
  int mismatch_count = 0;

  logic [9:0] frame;
  int         busy_cycles;
  logic       done_before;

  uart_tx #(.BAUD_DIV(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data), .clr_done(clr_done),
    .TX(TX), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Pulse-or-hold trmt with a byte and clock the accepting edge.
  task automatic applyStimulus(input logic [7:0] data, input bit hold);
    tx_data = data;
    trmt = 1'b1;
    tick();
    if (!hold) trmt = 1'b0;
  endtask

  // Entered on frame cycle 1 (just after the accept edge); leaves on cycle 160.
  // A nonzero poke_at pulses trmt with 8'h3C after that cycle.
  task automatic captureFrame(input int poke_at, output logic [9:0] bits,
                              output int busy_n, output logic done_last);
    bits = '0;
    busy_n = 0;
    done_last = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      if (busy) busy_n++;
      if (c % 16 == 9) bits[(c - 1) / 16] = TX;
      if (c == 160) done_last = tx_done;
      if (poke_at != 0 && c == poke_at + 1) trmt = 1'b0;
      if (poke_at != 0 && c == poke_at) begin
        tx_data = 8'h3C;
        trmt = 1'b1;
      end
      if (c < 160) tick();
    end
  endtask

  initial begin
    #1;
    tick();
    tick();
    checkOutput("reset_tx", 32'(TX), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checkOutput("idle", 32'({TX, busy, tx_done}), 32'b100);
    end

    // Single A5 frame: start bit appears one clock after trmt.
    applyStimulus(8'hA5, 1'b0);
    checkOutput("a5_start", 32'(TX), 32'd0);
    captureFrame(0, frame, busy_cycles, done_before);
    checkOutput("a5_frame", 32'(frame), 32'h34A);
    checkOutput("a5_busy_cycles", 32'(busy_cycles), 32'd160);
    checkOutput("a5_done_early", 32'(done_before), 32'd0);
    tick();
    checkOutput("a5_done_161", 32'(tx_done), 32'd1);
    checkOutput("a5_busy_161", 32'(busy), 32'd0);
    checkOutput("a5_tx_idle", 32'(TX), 32'd1);

    // Explicit clear of a set tx_done.
    clr_done = 1'b1;
    tick();
    clr_done = 1'b0;
    checkOutput("clr_done", 32'(tx_done), 32'd0);

    // Back-to-back 00 then FF with trmt held across the first idle cycle.
    applyStimulus(8'h00, 1'b1);
    tx_data = 8'hFF;
    captureFrame(0, frame, busy_cycles, done_before);
    checkOutput("b2b_frame00", 32'(frame), 32'h200);
    tick();
    checkOutput("b2b_stop_161", 32'(TX), 32'd1);
    checkOutput("b2b_done_161", 32'(tx_done), 32'd1);
    tick();
    trmt = 1'b0;
    checkOutput("b2b_start2", 32'(TX), 32'd0);
    checkOutput("b2b_done_clr", 32'(tx_done), 32'd0);
    captureFrame(0, frame, busy_cycles, done_before);
    checkOutput("b2b_frameFF", 32'(frame), 32'h3FE);
    checkOutput("b2b_busy_cycles", 32'(busy_cycles), 32'd160);
    tick();
    checkOutput("b2b_done2", 32'(tx_done), 32'd1);

    // trmt while busy is ignored and leaves no extra frame behind.
    applyStimulus(8'hA5, 1'b0);
    captureFrame(40, frame, busy_cycles, done_before);
    checkOutput("ign_frame", 32'(frame), 32'h34A);
    tick();
    checkOutput("ign_done", 32'(tx_done), 32'd1);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy || !TX) busy_cycles++;
    end
    checkOutput("ign_no_extra", 32'(busy_cycles), 32'd0);

    // Reset mid-frame abandons it without setting tx_done.
    applyStimulus(8'hA5, 1'b0);
    for (int c = 1; c < 75; c++) tick();
    checkOutput("abort_pre_tx", 32'(TX), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("abort_tx", 32'(TX), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) tick();
    checkOutput("abort_late", 32'({TX, busy, tx_done}), 32'b100);
    applyStimulus(8'h5A, 1'b0);
    captureFrame(0, frame, busy_cycles, done_before);
    checkOutput("post_rst_frame", 32'(frame), 32'h2B4);
    tick();
    checkOutput("post_rst_done", 32'(tx_done), 32'd1);

    // Clear and set on the same edge: set wins, the next clear takes effect.
    applyStimulus(8'h81, 1'b0);
    checkOutput("sw_cleared_by_trmt", 32'(tx_done), 32'd0);
    captureFrame(0, frame, busy_cycles, done_before);
    checkOutput("sw_frame", 32'(frame), 32'h302);
    clr_done = 1'b1;
    tick();
    checkOutput("sw_set_wins", 32'(tx_done), 32'd1);
    tick();
    clr_done = 1'b0;
    checkOutput("sw_clear_after", 32'(tx_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
